sram_controller: RTL and testbench
==================================

# sram_controller

Sequencer between the MEM stage and the off-chip 16-bit SRAM that backs data memory. It turns one 32-bit load or store into two 16-bit SRAM accesses, low half first, each stretched by a programmable number of wait states. While an access is in progress it holds `ready` low; the top level drives the pipeline-wide `freeze` from `~ready`, so every stage register stalls until the access completes.

## Interface
- `WAIT_STATES`, default 1: extra cycles per 16-bit half-access (0..15).
- `DATA_BASE`, default 1024: byte address mapped to SRAM word 0.
- `clk`  in  1  pipeline clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rd_en`  in  1  MEM-stage load request (level).
- `wr_en`  in  1  MEM-stage store request (level).
- `address`  in  32  byte address from the ALU result.
- `write_data`  in  32  store data (`val_rm`).
- `read_data`  out  32  load result; valid while `ready` is high in DONE.
- `ready`  out  1  combinational; low means "freeze the pipeline".
- `sram_addr`  out  18  SRAM half-word address.
- `sram_dq_in`  in  16  SRAM data bus, read direction.
- `sram_dq_out`  out  16  SRAM data bus, write direction.
- `sram_dq_oe`  out  1  drives `sram_dq_out` onto the pad when 1.
- `sram_we_n`  out  1  SRAM write enable, active low.

## Operation
- **States:** IDLE, LO, HI, DONE. There is a 4-bit wait counter `cnt`.
- **IDLE**
  - If `wr_en | rd_en` is high at a rising edge: latch `op`, latch `word = (address - DATA_BASE)[18:2]` (32-bit subtract, no range check), latch `write_data`, set `cnt = 0`, go to LO.
  - `wr_en` takes priority when both requests are high: the operation is a write and `read_data` is untouched.
- **LO**
  - `sram_addr = {word, 1'b0}`.
  - For a write: `sram_dq_out = wdata[15:0]`, `sram_dq_oe = 1`, `sram_we_n = 0`.
  - While `cnt < WAIT_STATES`: `cnt++`.
  - When `cnt == WAIT_STATES`: for a read, capture `read_data[15:0] <= sram_dq_in`; then `cnt = 0` and go to HI.
- **HI**
  - Same as LO, except `sram_addr = {word, 1'b1}` and the data is `wdata[31:16]` / `read_data[31:16]`.
  - At the end of the phase, go to DONE.
- **DONE:** `ready = 1` for exactly one cycle, then go to IDLE unconditionally. Requests are ignored in this state.
- **`ready` equation:** `(state == DONE) | (state == IDLE & ~rd_en & ~wr_en)`.
- **Latching:** changes on `address`, `write_data` or `op` after the IDLE→LO edge have no effect; the access always completes.
- **Outputs outside LO/HI:** `sram_addr = 0`, `sram_dq_oe = 0`, `sram_we_n = 1`, `sram_dq_out = 0`.
- **`read_data`:** holds its last value until the next read overwrites it.

## Timing
- **Reset, asynchronous and applicable mid-access:**
  - state = IDLE, `cnt = 0`, `read_data = 0`.
  - `sram_we_n = 1`, `sram_dq_oe = 0`, `sram_addr = 0`, `sram_dq_out = 0`.
  - `ready = ~(rd_en | wr_en)`.
  - An interrupted write may leave the SRAM partially updated; this is accepted behaviour.
- **Latency:** request high in IDLE at cycle k → `ready` high in cycle k + 1 + 2·(WAIT_STATES+1).
  - With WAIT_STATES = 1 this is cycle k+5, i.e. 5 cycles with `ready` low.
- **Read capture:** on the last cycle of each phase, i.e. `sram_dq_in` is sampled WAIT_STATES+1 cycles after `sram_addr` changed.
- **Back-to-back accesses:**
  - The pipeline advances on the edge that ends DONE.
  - If the next instruction also requests, IDLE sees it in the following cycle, so `ready` goes low again combinationally.
  - There is one IDLE cycle between accesses.
- **Request with no memory op:** `ready` stays high and there is no SRAM activity.

## Test plan
- **Reset check:** assert `rst` asynchronously.
  - Required: `sram_we_n = 1`, `sram_dq_oe = 0`, `read_data = 0`, and `ready = 1` with no request.
- **Store then load, WAIT_STATES = 1:** store `address = 1028`, `write_data = 0xDEADBEEF`.
  - Required write: `sram_addr = 2` (data 0xBEEF) for 2 cycles, then `sram_addr = 3` (data 0xDEAD) for 2 cycles, with `sram_we_n` low for those 4 cycles; `ready` high only at k+5.
  - Then load from 1028. Required: `read_data = 0xDEADBEEF` when `ready` rises.
- **Priority:** `rd_en = wr_en = 1`, `address = 1024`, data 0x12345678.
  - Required: a write is performed and `read_data` keeps its previous value.
- **Mid-access reset:** assert `rst` in HI.
  - Required: the FSM is in IDLE immediately, `sram_we_n = 1` with no clock edge needed.
  - Then a fresh load completes normally.
- **Input stability:** change `address` and `write_data` during LO.
  - Required: the latched word and data are used; `sram_addr` is unaffected.
- **WAIT_STATES = 0 with back-to-back loads:** two consecutive loads.
  - Required: each has 3 cycles with `ready` low, and there is exactly one IDLE cycle between them.

Source files
------------

// File: rtl/sram_controller.sv
// Splits each 32-bit MEM-stage load/store into two 16-bit SRAM accesses
// (low half first), each held for WAIT_STATES+1 cycles, stalling via ready.
module sram_controller #(
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] DATA_BASE   = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  input  logic [15:0] sram_dq_in,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  output logic        sram_we_n
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_t      state;
  logic [3:0]  cnt;
  logic        op_wr;
  logic [16:0] word;
  logic [31:0] wdata;
  logic [31:0] offset;
  logic        unused_offset_bits;

  // Only bits [18:2] of the rebased address select an SRAM word.
  assign offset             = address - DATA_BASE;
  assign unused_offset_bits = ^{offset[31:19], offset[1:0]};

  assign ready = (state == DONE) | ((state == IDLE) & ~rd_en & ~wr_en);

  // Bus outputs are registered: they are loaded on the edge entering each phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      op_wr       <= 1'b0;
      word        <= 17'd0;
      wdata       <= 32'd0;
      read_data   <= 32'd0;
      sram_addr   <= 18'd0;
      sram_dq_out <= 16'd0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (wr_en | rd_en) begin
            op_wr       <= wr_en;
            word        <= offset[18:2];
            wdata       <= write_data;
            cnt         <= 4'd0;
            state       <= LO;
            sram_addr   <= {offset[18:2], 1'b0};
            sram_we_n   <= ~wr_en;
            sram_dq_oe  <= wr_en;
            sram_dq_out <= wr_en ? write_data[15:0] : 16'd0;
          end
        end
        LO: begin
          if (cnt == WS) begin
            if (!op_wr) read_data[15:0] <= sram_dq_in;
            cnt         <= 4'd0;
            state       <= HI;
            sram_addr   <= {word, 1'b1};
            sram_dq_out <= op_wr ? wdata[31:16] : 16'd0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        HI: begin
          if (cnt == WS) begin
            if (!op_wr) read_data[31:16] <= sram_dq_in;
            cnt         <= 4'd0;
            state       <= DONE;
            sram_addr   <= 18'd0;
            sram_we_n   <= 1'b1;
            sram_dq_oe  <= 1'b0;
            sram_dq_out <= 16'd0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Randomized and directed bench for sram_controller against a word-level
// memory model; a second instance exercises zero wait states back-to-back.
module tb_sram_controller;

  localparam int W = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        rd_en = 1'b0, wr_en = 1'b0;
  logic [31:0] address = 32'd0, write_data = 32'd0;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] dq_in = 16'd0, dq_out;
  logic        oe, we_n;

  logic        b_rd_en = 1'b0, b_wr_en = 1'b0;
  logic [31:0] b_address = 32'd0, b_write_data = 32'd0;
  logic [31:0] b_read_data;
  logic        b_ready;
  logic [17:0] b_sram_addr;
  logic [15:0] b_dq_in = 16'd0, b_dq_out;
  logic        b_oe, b_we_n;

  sram_controller #(.WAIT_STATES(W), .DATA_BASE(32'd1024)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready),
    .sram_addr(sram_addr), .sram_dq_in(dq_in), .sram_dq_out(dq_out),
    .sram_dq_oe(oe), .sram_we_n(we_n)
  );

  sram_controller #(.WAIT_STATES(0), .DATA_BASE(32'd1024)) dut0 (
    .clk(clk), .rst(rst), .rd_en(b_rd_en), .wr_en(b_wr_en), .address(b_address),
    .write_data(b_write_data), .read_data(b_read_data), .ready(b_ready),
    .sram_addr(b_sram_addr), .sram_dq_in(b_dq_in), .sram_dq_out(b_dq_out),
    .sram_dq_oe(b_oe), .sram_we_n(b_we_n)
  );

  int checks = 0;
  int errors = 0;

  // Power-up content of a never-written SRAM location.
  function automatic logic [15:0] fill(input logic [17:0] a);
    logic [31:0] t;
    t = {14'd0, a} * 32'h9E37 + 32'h1234;
    return t[15:0];
  endfunction

  // Off-chip SRAM: writes and read-data presentation on the falling edge.
  logic [15:0] mem [logic [17:0]];
  always @(negedge clk) begin
    if (!we_n && oe) mem[sram_addr] = dq_out;
    dq_in   <= mem.exists(sram_addr) ? mem[sram_addr] : fill(sram_addr);
    b_dq_in <= fill(b_sram_addr);
  end

  // Word-level reference: what a 32-bit load of a given word must return.
  logic [31:0] ref32 [logic [16:0]];
  logic [31:0] exp_rd = 32'd0;

  function automatic logic [31:0] model_read(input logic [16:0] w);
    if (ref32.exists(w)) return ref32[w];
    return {fill({w, 1'b1}), fill({w, 1'b0})};
  endfunction

  function automatic logic [16:0] word_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'd1024;
    return off[18:2];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic access(input bit wr, input bit rd, input logic [31:0] addr,
                        input logic [31:0] data);
    logic [16:0] w;
    logic        hi;
    logic        exp_we;
    w      = word_of(addr);
    exp_we = !wr;
    @(negedge clk);
    wr_en = wr; rd_en = rd; address = addr; write_data = data;
    #1;
    check("req_ready_low", ready, 0);
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0;
    address = $urandom; write_data = $urandom;
    if (!wr) exp_rd = model_read(w);
    for (int i = 1; i <= 2 * W + 3; i++) begin
      @(negedge clk);
      if (i <= 2 * W + 2) begin
        hi = (i > W + 1);
        check("busy_ready", ready, 0);
        check("sram_addr", sram_addr, {w, hi});
        check("we_n", we_n, exp_we);
        check("oe", oe, wr);
        if (wr) check("dq_out", dq_out, hi ? data[31:16] : data[15:0]);
      end else begin
        check("done_ready", ready, 1);
        check("read_data", read_data, exp_rd);
      end
    end
    if (wr) ref32[w] = data;
    @(negedge clk);
    check("idle_ready", ready, 1);
    check("rd_hold", read_data, exp_rd);
    $display("access wr=%0b rd=%0b addr=%h word=%h data=%h read_data=%h", wr, rd, addr, w, data, read_data);
  endtask

  initial begin
    // Asynchronous reset, no clock edge involved.
    #2 rst = 1'b1;
    #1;
    check("rst_we_n", we_n, 1);
    check("rst_oe", oe, 0);
    check("rst_read_data", read_data, 0);
    check("rst_sram_addr", sram_addr, 0);
    check("rst_ready", ready, 1);
    rd_en = 1'b1;
    #1;
    check("rst_ready_req", ready, 0);
    rd_en = 1'b0;
    #10 rst = 1'b0;

    access(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF);
    access(1'b0, 1'b1, 32'd1028, 32'h0);
    access(1'b1, 1'b1, 32'd1024, 32'h12345678);
    access(1'b0, 1'b1, 32'd1024, 32'h0);
    access(1'b1, 1'b0, 32'd1020, 32'hA5A55A5A);
    access(1'b0, 1'b1, 32'd1020, 32'h0);

    // Reset asserted during the HI phase of a store to word 100.
    @(negedge clk);
    wr_en = 1'b1; address = 32'd1424; write_data = 32'hCAFEF00D;
    @(posedge clk);
    #1 wr_en = 1'b0;
    repeat (W + 2) @(negedge clk);
    check("hi_addr", sram_addr, {17'd100, 1'b1});
    #2 rst = 1'b1;
    #1;
    check("mid_rst_we_n", we_n, 1);
    check("mid_rst_oe", oe, 0);
    check("mid_rst_addr", sram_addr, 0);
    check("mid_rst_read_data", read_data, 0);
    check("mid_rst_ready", ready, 1);
    rst = 1'b0;
    exp_rd = 32'd0;
    $display("mid-access reset applied in HI");
    access(1'b0, 1'b1, 32'd1028, 32'h0);

    for (int n = 0; n < 24; n++) begin
      int          op;
      logic [31:0] a;
      op = $urandom_range(0, 2);
      a  = 32'd1024 + 32'($urandom_range(0, 31)) * 4 + 32'($urandom_range(0, 3));
      access(op != 1, op != 0, a, $urandom);
    end

    // Zero wait states, rd_en held across two consecutive loads.
    begin
      logic [16:0] a1, a2;
      logic        exp_r;
      a1 = 17'd7;
      a2 = 17'd300;
      @(negedge clk);
      b_rd_en = 1'b1;
      b_address = 32'd1024 + {13'd0, a1, 2'b00};
      for (int c = 0; c < 8; c++) begin
        if (c > 0) @(negedge clk);
        #1;
        exp_r = (c % 4 == 3);
        check("b2b_ready", b_ready, exp_r);
        if (c == 3) begin
          check("b2b_read1", b_read_data, {fill({a1, 1'b1}), fill({a1, 1'b0})});
          b_address = 32'd1024 + {13'd0, a2, 2'b00};
        end
        if (c == 7) begin
          check("b2b_read2", b_read_data, {fill({a2, 1'b1}), fill({a2, 1'b0})});
          b_rd_en = 1'b0;
        end
        $display("b2b cycle %0d ready=%0b read_data=%h", c, b_ready, b_read_data);
      end
      @(negedge clk);
      check("b2b_idle_ready", b_ready, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
